// File: rtl/ram_bsram_device_pkg.sv
// RAM_IF shared definitions: DIN_SIZE codes, device FSM states,
// byte-lane enable and read-rotate helpers.
package RAM;

    localparam logic [1:0] DIN_SIZE_8  = 2'b00;
    localparam logic [1:0] DIN_SIZE_16 = 2'b01;
    localparam logic [1:0] DIN_SIZE_32 = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_DATA,
        ACK
    } DEV_STATE_t;

    function automatic logic [3:0] be_from_size(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        unique case (size)
            DIN_SIZE_8:  be = 4'b0001 << lane;
            DIN_SIZE_16: be = lane[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Right-aligned host data replicated so every enabled lane sees its byte.
    function automatic logic [31:0] wdata_from_size(
        input logic [31:0] din,
        input logic [1:0]  size
    );
        logic [31:0] w;
        unique case (size)
            DIN_SIZE_8:  w = {4{din[7:0]}};
            DIN_SIZE_16: w = {2{din[15:0]}};
            default:     w = din;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] rotr32(
        input logic [31:0] word,
        input logic [1:0]  lane
    );
        logic [31:0] r;
        unique case (lane)
            2'd0:    r = word;
            2'd1:    r = {word[7:0],  word[31:8]};
            2'd2:    r = {word[15:0], word[31:16]};
            default: r = {word[23:0], word[31:24]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_if.sv
// RAM_IF bus: host issues strobes, device answers with ACK_n
// and provides the TIMING slot strobe.
interface RAM_IF #(
    parameter int ADDR_BIT_WIDTH = 24
);
    logic [ADDR_BIT_WIDTH-1:0] ADDR;
    logic                      OE_n;
    logic                      WE_n;
    logic                      RFSH_n;
    logic [31:0]               DIN;
    logic [1:0]                DIN_SIZE;
    logic [31:0]               DOUT;
    logic                      ACK_n;
    logic                      TIMING;

    modport DEVICE (
        input  ADDR, OE_n, WE_n, RFSH_n, DIN, DIN_SIZE,
        output DOUT, ACK_n, TIMING
    );

    modport HOST (
        output ADDR, OE_n, WE_n, RFSH_n, DIN, DIN_SIZE,
        input  DOUT, ACK_n, TIMING
    );
endinterface

// File: rtl/ram_bsram_array.sv
// Single-port 32-bit block RAM, per-byte write enables, registered
// read (read-before-write). Isolated so a vendor primitive can replace it.
module ram_bsram_array #(
    parameter int AW = 10
) (
    input  logic          CLK,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/ram_bsram_device.sv
// RAM_IF device responder backed by ram_bsram_array: slot strobe,
// request decode, byte-enabled writes, rotated reads, ACK_n handshake.
module ram_bsram_device
    import RAM::*;
#(
    parameter int ADDR_BIT_WIDTH = 24,
    parameter int MEM_ADDR_BITS  = 10,
    parameter int TIMING_PERIOD  = 4
) (
    input  logic   CLK,
    input  logic   RESET_n,
    RAM_IF.DEVICE  Bus,
    output logic   BUSY
);
    localparam int         LW        = MEM_ADDR_BITS + 2;
    localparam logic [7:0] SLOT_LAST = 8'(TIMING_PERIOD - 1);

    DEV_STATE_t  state;
    logic [7:0]  slot_q;
    logic        ack_q;
    logic [31:0] dout_q;
    logic [LW-1:0] addr_q;
    logic [31:0] din_q;
    logic [1:0]  size_q;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            slot_q <= '0;
        end else if (slot_q == SLOT_LAST) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state  <= IDLE;
            ack_q  <= 1'b1;
            dout_q <= '0;
            addr_q <= '0;
            din_q  <= '0;
            size_q <= DIN_SIZE_8;
        end else begin
            unique case (state)
                IDLE: begin
                    // Sampled every idle cycle, so the value held is the one at exit.
                    addr_q <= Bus.ADDR[LW-1:0];
                    din_q  <= Bus.DIN;
                    size_q <= Bus.DIN_SIZE;
                    if (!Bus.WE_n) begin
                        state <= WR;
                    end else if (!Bus.OE_n) begin
                        state <= RD_ISSUE;
                    end else if (!Bus.RFSH_n) begin
                        state <= ACK;
                        ack_q <= 1'b0;
                    end
                end
                WR: begin
                    state <= ACK;
                    ack_q <= 1'b0;
                end
                RD_ISSUE: state <= RD_DATA;
                RD_DATA: begin
                    dout_q <= rotr32(mem_rdata, addr_q[1:0]);
                    ack_q  <= 1'b0;
                    state  <= ACK;
                end
                ACK: begin
                    if (Bus.OE_n && Bus.WE_n && Bus.RFSH_n) begin
                        ack_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is gated by the state register, so reset cancels a write whole.
    assign mem_en    = (state == WR) || (state == RD_ISSUE);
    assign mem_we    = (state == WR) ? be_from_size(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_wdata = wdata_from_size(din_q, size_q);

    ram_bsram_array #(
        .AW (MEM_ADDR_BITS)
    ) u_array (
        .CLK   (CLK),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_q[LW-1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign Bus.DOUT   = dout_q;
    assign Bus.ACK_n  = ack_q;
    assign Bus.TIMING = (slot_q == SLOT_LAST);
    assign BUSY       = (state != IDLE);

endmodule

// File: tb/tb_ram_bsram_device.sv
// Directed bench for ram_bsram_device: slot strobe, latencies,
// byte/half/word writes, rotated reads, priority, mirror, reset.
module tb_ram_bsram_device;
    import RAM::*;

    logic CLK = 1'b0;
    logic RESET_n = 1'b0;
    logic BUSY;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] rd;

    RAM_IF #(.ADDR_BIT_WIDTH(24)) bus ();

    ram_bsram_device #(
        .ADDR_BIT_WIDTH (24),
        .MEM_ADDR_BITS  (10),
        .TIMING_PERIOD  (4)
    ) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .Bus     (bus.DEVICE),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wait_ack(input int start, output int lat);
        lat = start;
        while (bus.ACK_n !== 1'b0 && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    task automatic release_all();
        bus.OE_n   = 1'b1;
        bus.WE_n   = 1'b1;
        bus.RFSH_n = 1'b1;
        cyc();
        check("ack_rel", 32'(bus.ACK_n), 32'd1);
        check("busy_idle", 32'(BUSY), 32'd0);
    endtask

    task automatic do_write(input logic [23:0] a, input logic [31:0] d,
                            input logic [1:0] sz);
        int lat;
        bus.ADDR     = a;
        bus.DIN      = d;
        bus.DIN_SIZE = sz;
        bus.WE_n     = 1'b0;
        cyc();
        bus.ADDR     = ~a;
        bus.DIN      = ~d;
        bus.DIN_SIZE = ~sz;
        wait_ack(1, lat);
        check("wr_lat", 32'(lat), 32'd2);
        release_all();
    endtask

    task automatic do_read(input logic [23:0] a, output logic [31:0] d);
        int lat;
        bus.ADDR = a;
        bus.OE_n = 1'b0;
        cyc();
        bus.ADDR = ~a;
        wait_ack(1, lat);
        check("rd_lat", 32'(lat), 32'd3);
        d = bus.DOUT;
        cyc();
        check("rd_hold", 32'(bus.ACK_n), 32'd0);
        release_all();
    endtask

    initial begin
        int lat;
        logic [31:0] exp_rot [4];
        exp_rot[0] = 32'h11223344;
        exp_rot[1] = 32'h44112233;
        exp_rot[2] = 32'h33441122;
        exp_rot[3] = 32'h22334411;

        bus.ADDR = '0;
        bus.DIN = '0;
        bus.DIN_SIZE = DIN_SIZE_8;
        bus.OE_n = 1'b1;
        bus.WE_n = 1'b1;
        bus.RFSH_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_ack", 32'(bus.ACK_n), 32'd1);
        check("rst_dout", bus.DOUT, 32'd0);
        check("rst_timing", 32'(bus.TIMING), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);

        RESET_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("timing", 32'(bus.TIMING), (k % 4 == 3) ? 32'd1 : 32'd0);
            check("idle_ack", 32'(bus.ACK_n), 32'd1);
            check("idle_dout", bus.DOUT, 32'd0);
            cyc();
        end

        do_write(24'h000010, 32'h11223344, DIN_SIZE_32);
        for (int i = 0; i < 4; i++) begin
            do_read(24'h000010 + 24'(i), rd);
            check("rd_rot", rd, exp_rot[i]);
        end

        do_write(24'h000012, 32'h000000AA, DIN_SIZE_8);
        do_read(24'h000010, rd);
        check("rd_b2", rd, 32'h11AA3344);
        do_write(24'h000013, 32'h0000BEEF, DIN_SIZE_16);
        do_read(24'h000010, rd);
        check("rd_h1", rd, 32'hBEEF3344);

        bus.ADDR = 24'h000020;
        bus.DIN = 32'h00000055;
        bus.DIN_SIZE = DIN_SIZE_8;
        bus.WE_n = 1'b0;
        bus.OE_n = 1'b0;
        bus.RFSH_n = 1'b0;
        wait_ack(0, lat);
        check("prio_lat", 32'(lat), 32'd2);
        check("prio_dout", bus.DOUT, 32'hBEEF3344);
        release_all();
        do_read(24'h000020, rd);
        check("prio_rd", {24'd0, rd[7:0]}, 32'h00000055);

        do_write(24'h000000, 32'hCAFE0000, DIN_SIZE_32);
        do_write(24'h001000, 32'h0000005A, DIN_SIZE_8);
        do_read(24'h000000, rd);
        check("mirror", rd, 32'hCAFE005A);

        bus.RFSH_n = 1'b0;
        wait_ack(0, lat);
        check("rfsh_lat", 32'(lat), 32'd1);
        check("rfsh_dout", bus.DOUT, 32'hCAFE005A);
        release_all();
        do_read(24'h000000, rd);
        check("rfsh_rd", rd, 32'hCAFE005A);

        bus.ADDR = 24'h000010;
        bus.OE_n = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("busy_rd", 32'(BUSY), 32'd1);
        RESET_n = 1'b0;
        #1;
        check("arst_ack", 32'(bus.ACK_n), 32'd1);
        check("arst_dout", bus.DOUT, 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        bus.OE_n = 1'b1;
        @(negedge CLK);
        RESET_n = 1'b1;
        cyc();
        do_read(24'h000010, rd);
        check("post_rst", rd, 32'hBEEF3344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
